// File: rtl/object_plotter.sv
// Object plotter: walks a 2**OBJ_XBITS x 2**OBJ_YBITS object memory and
// emits one VGA pixel per cycle. Off-screen and transparent pixels are
// suppressed. Erase mode fills the object box with a single colour instead.
module object_plotter #(
  parameter int          XBITS       = 8,
  parameter int          OBJ_XBITS   = 4,
  parameter int          OBJ_YBITS   = 4,
  parameter int          MEM_LATENCY = 1,
  parameter int          SCREEN_W    = 160,
  parameter int          SCREEN_H    = 120,
  parameter logic [23:0] TRANSPARENT = 24'hFF00FF
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           erase,
  input  logic [XBITS-1:0]               x_pos,
  input  logic [XBITS-2:0]               y_pos,
  input  logic [23:0]                    bg_color,
  output logic [OBJ_XBITS+OBJ_YBITS-1:0] mem_addr,
  input  logic [23:0]                    mem_data,
  output logic [XBITS-1:0]               VGA_X,
  output logic [XBITS-2:0]               VGA_Y,
  output logic [23:0]                    VGA_COLOR,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int AW = OBJ_XBITS + OBJ_YBITS;
  localparam int CW = MEM_LATENCY * OBJ_XBITS;
  localparam int RW = MEM_LATENCY * OBJ_YBITS;
  localparam logic [XBITS:0]   SW_LIM = (XBITS+1)'(SCREEN_W);
  localparam logic [XBITS-1:0] SH_LIM = XBITS'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [AW-1:0]      counter;
  logic [XBITS-1:0]   x_base;
  logic [XBITS-2:0]   y_base;
  logic               erase_mode;
  logic [23:0]        bg_latched;
  logic [MEM_LATENCY-1:0] stage_valid;
  logic [CW-1:0]      stage_col;
  logic [RW-1:0]      stage_row;

  logic               out_valid;
  logic [OBJ_XBITS-1:0] out_col;
  logic [OBJ_YBITS-1:0] out_row;
  logic [XBITS:0]     x_sum;
  logic [XBITS-1:0]   y_sum;
  logic               opaque;

  // State register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: start only counts in IDLE; flush waits for the read pipeline to drain
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DRAW;
      DRAW:    if (&counter) state_next = FLUSH;
      FLUSH:   if (stage_valid == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture object parameters at start so input changes mid-draw are harmless
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      x_base     <= '0;
      y_base     <= '0;
      erase_mode <= 1'b0;
      bg_latched <= '0;
    end else if (state == IDLE && start) begin
      x_base     <= x_pos;
      y_base     <= y_pos;
      erase_mode <= erase;
      bg_latched <= bg_color;
    end
  end

  // Address counter; wrapping past the maximum leaves it at 0 for the next object
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)              counter <= '0;
    else if (state == DRAW) counter <= counter + 1'b1;
  end

  // Coordinate pipeline delays col/row by the memory latency to meet mem_data
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stage_valid <= '0;
      stage_col   <= '0;
      stage_row   <= '0;
    end else begin
      stage_valid <= (stage_valid << 1) | MEM_LATENCY'(state == DRAW);
      stage_col   <= (stage_col << OBJ_XBITS) | CW'(counter[OBJ_XBITS-1:0]);
      stage_row   <= (stage_row << OBJ_YBITS) | RW'(counter[AW-1:OBJ_XBITS]);
    end
  end

  // Pixel output: clip on unwrapped coordinates, skip transparent colour in draw mode
  always_comb begin
    out_valid = stage_valid[MEM_LATENCY-1];
    out_col   = stage_col[CW-1 -: OBJ_XBITS];
    out_row   = stage_row[RW-1 -: OBJ_YBITS];
    x_sum     = {1'b0, x_base} + (XBITS+1)'(out_col);
    y_sum     = {1'b0, y_base} + XBITS'(out_row);
    opaque    = erase_mode || (mem_data != TRANSPARENT);
    plot      = out_valid && (x_sum < SW_LIM) && (y_sum < SH_LIM) && opaque;
    VGA_X     = out_valid ? x_sum[XBITS-1:0] : '0;
    VGA_Y     = out_valid ? y_sum[XBITS-2:0] : '0;
    VGA_COLOR = out_valid ? (erase_mode ? bg_latched : mem_data) : '0;
  end

  assign mem_addr = counter;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_object_plotter.sv
// Self-checking bench for object_plotter: table vectors, randomized objects
// against a pixel-list model, and a reset-abort sequence.
module tb_object_plotter;

  localparam int LAT    = 3;
  localparam int OXB    = 2;
  localparam int OYB    = 2;
  localparam int NPIX   = 1 << (OXB + OYB);
  localparam int SW     = 160;
  localparam int SH     = 120;
  localparam logic [23:0] TRANSP = 24'hFF00FF;
  localparam int DONE_AT = NPIX + LAT + 1;
  localparam int WINDOW  = DONE_AT + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        erase;
  logic [7:0]  x_pos;
  logic [6:0]  y_pos;
  logic [23:0] bg_color;
  logic [3:0]  mem_addr;
  logic [23:0] mem_data;
  logic [7:0]  VGA_X;
  logic [6:0]  VGA_Y;
  logic [23:0] VGA_COLOR;
  logic        plot;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [23:0] mem [NPIX];
  logic [23:0] rd_pipe [LAT];

  bit          exp_plot [WINDOW+1];
  int          exp_x    [WINDOW+1];
  int          exp_y    [WINDOW+1];
  logic [23:0] exp_c    [WINDOW+1];

  typedef struct {
    int          x;
    int          y;
    bit          er;
    logic [23:0] bg;
    bit          holes;
    int          exp_plots;
  } vec_t;

  vec_t vecs [9];

  object_plotter #(
    .XBITS(8), .OBJ_XBITS(OXB), .OBJ_YBITS(OYB), .MEM_LATENCY(LAT),
    .SCREEN_W(SW), .SCREEN_H(SH), .TRANSPARENT(TRANSP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .erase(erase),
    .x_pos(x_pos), .y_pos(y_pos), .bg_color(bg_color),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Object memory with a fixed read latency of LAT cycles
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data = rd_pipe[LAT-1];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic load_mem(input bit holes);
    for (int a = 0; a < NPIX; a++) mem[a] = 24'h3C5A00 + 24'(a);
    if (holes) begin
      mem[5]  = TRANSP;
      mem[10] = TRANSP;
    end
  endtask

  // Expected pixel list: pixel for address a lands LAT cycles after its issue cycle a
  task automatic build_model(input int x, input int y, input bit er, input logic [23:0] bg, output int count);
    count = 0;
    for (int k = 0; k <= WINDOW; k++) exp_plot[k] = 1'b0;
    for (int a = 0; a < NPIX; a++) begin
      int col = a % (1 << OXB);
      int row = a / (1 << OXB);
      int ux = x + col;
      int uy = y + row;
      if (ux < SW && uy < SH && (er || mem[a] != TRANSP)) begin
        exp_plot[LAT + a] = 1'b1;
        exp_x[LAT + a]    = ux % 256;
        exp_y[LAT + a]    = uy % 128;
        exp_c[LAT + a]    = er ? bg : mem[a];
        count++;
      end
    end
  endtask

  // Launch one object and check every cycle until it has settled back in IDLE;
  // start and the object inputs are scrambled while busy, including the DONE cycle
  task automatic apply_stimulus(input int x, input int y, input bit er, input logic [23:0] bg, output int seen);
    int model_count;
    build_model(x, y, er, bg, model_count);
    seen = 0;
    @(negedge clk);
    x_pos = 8'(x); y_pos = 7'(y); erase = er; bg_color = bg; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= WINDOW; k++) begin
      @(negedge clk);
      check_output($sformatf("plot@%0d", k), 32'(plot), 32'(exp_plot[k]));
      if (exp_plot[k]) begin
        check_output($sformatf("vga_x@%0d", k), 32'(VGA_X), 32'(exp_x[k]));
        check_output($sformatf("vga_y@%0d", k), 32'(VGA_Y), 32'(exp_y[k]));
        check_output($sformatf("color@%0d", k), 32'(VGA_COLOR), 32'(exp_c[k]));
      end
      if (plot) seen++;
      check_output($sformatf("done@%0d", k), 32'(done), 32'(k == DONE_AT));
      check_output($sformatf("busy@%0d", k), 32'(busy), 32'(k <= DONE_AT));
      if (k < NPIX) check_output($sformatf("mem_addr@%0d", k), 32'(mem_addr), 32'(k));
      if (k <= DONE_AT) begin
        start    = 1'($urandom);
        x_pos    = 8'($urandom);
        y_pos    = 7'($urandom);
        erase    = 1'($urandom);
        bg_color = 24'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check_output("model_count", 32'(seen), 32'(model_count));
  endtask

  initial begin
    int seen;

    vecs[0] = '{x: 10,  y: 20,  er: 0, bg: 24'h000000, holes: 0, exp_plots: 16};
    vecs[1] = '{x: 10,  y: 20,  er: 0, bg: 24'h000000, holes: 1, exp_plots: 14};
    vecs[2] = '{x: 10,  y: 20,  er: 1, bg: 24'h000000, holes: 1, exp_plots: 16};
    vecs[3] = '{x: 158, y: 118, er: 0, bg: 24'h000000, holes: 0, exp_plots: 4};
    vecs[4] = '{x: 158, y: 118, er: 0, bg: 24'h000000, holes: 1, exp_plots: 3};
    vecs[5] = '{x: 157, y: 20,  er: 0, bg: 24'h000000, holes: 0, exp_plots: 12};
    vecs[6] = '{x: 10,  y: 118, er: 0, bg: 24'h000000, holes: 0, exp_plots: 8};
    vecs[7] = '{x: 255, y: 127, er: 1, bg: 24'hABCDEF, holes: 0, exp_plots: 0};
    vecs[8] = '{x: 0,   y: 0,   er: 1, bg: 24'h123456, holes: 1, exp_plots: 16};

    reset = 1'b1; start = 1'b0; erase = 1'b0; x_pos = '0; y_pos = '0; bg_color = '0;
    load_mem(1'b0);
    #1;
    check_output("reset_plot", 32'(plot), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_addr", 32'(mem_addr), 32'd0);
    check_output("reset_vga_x", 32'(VGA_X), 32'd0);
    check_output("reset_vga_y", 32'(VGA_Y), 32'd0);
    check_output("reset_color", 32'(VGA_COLOR), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      load_mem(vecs[v].holes);
      apply_stimulus(vecs[v].x, vecs[v].y, vecs[v].er, vecs[v].bg, seen);
      check_output($sformatf("vec%0d_plots", v), 32'(seen), 32'(vecs[v].exp_plots));
    end

    for (int r = 0; r < 12; r++) begin
      int x;
      int y;
      for (int a = 0; a < NPIX; a++)
        mem[a] = ($urandom_range(0, 3) == 0) ? TRANSP : 24'($urandom);
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(110, 127) : $urandom_range(0, 119);
      apply_stimulus(x, y, 1'($urandom), 24'($urandom), seen);
    end

    // Reset mid-draw: a second start at cycle 5 is ignored, reset at cycle 8 aborts
    load_mem(1'b0);
    @(negedge clk);
    x_pos = 8'd10; y_pos = 7'd20; erase = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_output($sformatf("abort_addr@%0d", k), 32'(mem_addr), 32'(k));
      start = (k == 4);
    end
    @(negedge clk);
    check_output("abort_plot_before", 32'(plot), 32'd1);
    reset = 1'b1;
    #1;
    check_output("abort_plot", 32'(plot), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check_output($sformatf("post_abort_plot@%0d", k), 32'(plot), 32'd0);
      check_output($sformatf("post_abort_done@%0d", k), 32'(done), 32'd0);
      check_output($sformatf("post_abort_busy@%0d", k), 32'(busy), 32'd0);
    end
    apply_stimulus(10, 20, 1'b0, 24'h0, seen);
    check_output("fresh_plots", 32'(seen), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
